// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the 5-stage RISC-V core.
//
// Owns the PC and runs a single-outstanding request/grant/response port to
// instruction memory. Fetched instructions are presented as an if_pc/if_inst
// pair with if_valid; a transfer happens when if_valid=1 and stall_i=0.
// A one-entry skid buffer catches a response that arrives while the output
// register is still held by a stall. EX-stage redirects take priority over
// everything else, including stall.
//
// Optional feature (macro IF_MISALIGN_CHECK_EN):
//   defined   -> a redirect to a target with [1:0]!=0 issues no fetch and
//                presents a faulting NOP (if_fault_o=1) at that target; the
//                stage parks until the next aligned redirect.
//   undefined -> redirect target bits [1:0] are forced to 0, if_fault_o=0.
//
// Parameters:
//   ADDR_W    PC / memory address width
//   INST_W    instruction width
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   stall_i                       downstream cannot accept this cycle
//   redirect_i, redirect_pc_i     EX-stage redirect request and target
//   mem_req_o, mem_addr_o         fetch request and address
//   mem_gnt_i                     request accepted this cycle
//   mem_rvalid_i, mem_rdata_i     response valid and instruction
//   if_pc, if_inst, if_valid      presented instruction to IF/ID
//   if_fault_o                    misaligned-target fault marker
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid,
    output logic              if_fault_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              parked_q, parked_d;
    logic              skid_valid_q, skid_valid_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;

    logic [ADDR_W-1:0] out_pc_d;
    logic [INST_W-1:0] out_inst_d;
    logic              out_valid_d;

    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pc_inc;
    logic              slot_free;

`ifdef IF_MISALIGN_CHECK_EN
    localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);
    logic misalign;
    logic fault_q, fault_d;

    assign tgt      = redirect_pc_i;
    assign misalign = |redirect_pc_i[1:0];
`else
    assign tgt      = redirect_pc_i & ~ADDR_W'(3);
`endif

    assign pc_inc     = pc_q + ADDR_W'(4);
    assign slot_free  = !if_valid || !stall_i;
    assign mem_req_o  = (state_q == ST_REQ);
    assign mem_addr_o = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        parked_d     = parked_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        out_pc_d     = if_pc;
        out_inst_d   = if_inst;
        out_valid_d  = if_valid;
`ifdef IF_MISALIGN_CHECK_EN
        fault_d      = fault_q;
`endif

        // Presented instruction leaves this cycle; a new load below may
        // refill the slot in the same cycle.
        if (if_valid && !stall_i) begin
            out_valid_d = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
            fault_d     = 1'b0;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (!parked_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        pc_d = pc_inc;
                        if (slot_free) begin
                            out_valid_d = 1'b1;
                            out_pc_d    = pc_q;
                            out_inst_d  = mem_rdata_i;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_pc_d    = pc_q;
                            skid_inst_d  = mem_rdata_i;
                            state_d      = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_i && skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_pc_d     = skid_pc_q;
                    out_inst_d   = skid_inst_q;
                    skid_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect overrides the normal flow above. A request already granted
        // (or in flight in WAIT) still owes a response, so it is marked for
        // discard instead of issuing a second outstanding request.
        if (redirect_i) begin
            pc_d         = tgt;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            parked_d     = 1'b0;
            drop_d       = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
            fault_d      = 1'b0;
            if (misalign) begin
                state_d     = ST_IDLE;
                parked_d    = 1'b1;
                out_valid_d = 1'b1;
                out_pc_d    = redirect_pc_i;
                out_inst_d  = NOP;
                fault_d     = 1'b1;
            end else
`endif
            if ((state_q == ST_WAIT && !mem_rvalid_i) ||
                (state_q == ST_REQ && mem_gnt_i)) begin
                drop_d  = 1'b1;
                state_d = ST_WAIT;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            parked_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_inst_q  <= '0;
            if_pc        <= '0;
            if_inst      <= '0;
            if_valid     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            parked_q     <= parked_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            if_pc        <= out_pc_d;
            if_inst      <= out_inst_d;
            if_valid     <= out_valid_d;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign if_fault_o = fault_q;
`else
    assign if_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
// A behavioural memory (fixed word function of the address, random grant and
// response latency) drives the fetch port. A stream-level model tracks the
// next PC the core should receive: each transfer must carry exp_pc and the
// memory word at exp_pc, and a redirect restarts the stream at its target.
// A second instance with RESET_PC = 0xFFFF_FFF8 shares all inputs to cover
// address wrap-around.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] RST_PC_W = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    logic        mem_req_o, w_mem_req_o;
    logic [31:0] mem_addr_o, w_mem_addr_o;
    logic [31:0] if_pc, w_if_pc;
    logic [31:0] if_inst, w_if_inst;
    logic        if_valid, w_if_valid;
    logic        if_fault_o, w_if_fault_o;

    if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_fault_o(if_fault_o)
    );

    if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(RST_PC_W)) wdut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_o(w_mem_req_o), .mem_addr_o(w_mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .if_pc(w_if_pc), .if_inst(w_if_inst), .if_valid(w_if_valid), .if_fault_o(w_if_fault_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // memory model state
    bit          pending = 0;
    logic [31:0] paddr = '0;
    int unsigned cnt = 0;
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned stale_cycles = 0;
    logic [31:0] grants[$];
    logic [31:0] w_grants[$];

    // stream model state
    logic [31:0] exp_pc = RST_PC;
    bit          exp_fault = 0;
    bit          exp_none = 0;
    logic [31:0] xfers[$];
    int          cyc = 0;
    int          first_gnt_cyc = -1;
    int          first_valid_cyc = -1;

    bit          prev_hold = 0;
    bit          prev_req_wait = 0;
    logic [31:0] prev_pc = '0, prev_inst = '0, prev_addr = '0;
    logic        prev_fault = 1'b0;

    // Called at a falling edge with stall_i/redirect_i already set for the
    // coming rising edge; runs memory, checks, then advances one cycle.
    task automatic step();
        if (rst_n) check_eq("one_outstanding", 32'(mem_req_o && pending), 32'd0);
        if (prev_req_wait) begin
            check_eq("req_held", 32'(mem_req_o), 32'd1);
            check_eq("addr_held", mem_addr_o, prev_addr);
        end
        if (prev_hold) begin
            check_eq("hold_valid", 32'(if_valid), 32'd1);
            check_eq("hold_pc", if_pc, prev_pc);
            check_eq("hold_inst", if_inst, prev_inst);
            check_eq("hold_fault", 32'(if_fault_o), 32'(prev_fault));
        end
        if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hDEAD_BEEF;
        if (stale_cycles > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hBAD0_0BAD;
            stale_cycles--;
        end else if (pending) begin
            if (cnt <= 1) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(paddr);
                pending      = 0;
            end else begin
                cnt--;
            end
        end
        mem_gnt_i = 1'b0;
        if (rst_n && mem_req_o && !pending && stale_cycles == 0 &&
            $urandom_range(99) < gnt_pct) begin
            mem_gnt_i = 1'b1;
            pending   = 1;
            paddr     = mem_addr_o;
            cnt       = $urandom_range(lat_max, lat_min);
            grants.push_back(mem_addr_o);
            w_grants.push_back(w_mem_addr_o);
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        end

        if (rst_n && if_valid && !stall_i) begin
            if (exp_none) begin
                check_eq("xfer_unexpected", 32'(if_valid), 32'd0);
            end else begin
                check_eq("xfer_pc", if_pc, exp_pc);
                if (exp_fault) begin
                    check_eq("xfer_nop", if_inst, NOP);
                    check_eq("xfer_fault", 32'(if_fault_o), 32'd1);
                    exp_none = 1;
                end else begin
                    check_eq("xfer_inst", if_inst, mem_word(exp_pc));
                    check_eq("xfer_nofault", 32'(if_fault_o), 32'd0);
                    exp_pc = exp_pc + 32'd4;
                end
            end
            xfers.push_back(if_pc);
        end
        if (rst_n && redirect_i) begin
            exp_none = 0;
`ifdef IF_MISALIGN_CHECK_EN
            exp_pc    = redirect_pc_i;
            exp_fault = (redirect_pc_i[1:0] != 2'b00);
`else
            exp_pc    = redirect_pc_i & ~32'h3;
            exp_fault = 0;
`endif
        end

        prev_hold     = rst_n && if_valid && stall_i && !redirect_i;
        prev_pc       = if_pc;
        prev_inst     = if_inst;
        prev_fault    = if_fault_o;
        prev_req_wait = rst_n && mem_req_o && !mem_gnt_i && !redirect_i;
        prev_addr     = mem_addr_o;
        cyc++;
        @(negedge clk);
    endtask

    task automatic assert_reset();
        rst_n        = 1'b0;
        stall_i      = 1'b0;
        redirect_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        pending      = 0;
        stale_cycles = 0;
        prev_hold    = 0;
        prev_req_wait = 0;
        exp_pc       = RST_PC;
        exp_fault    = 0;
        exp_none     = 0;
        grants.delete();
        w_grants.delete();
        xfers.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        cyc = 0;
        first_gnt_cyc = -1;
        first_valid_cyc = -1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        step();
        redirect_i    = 1'b0;
    endtask

    task automatic run_until_valid(input string tag);
        for (int i = 0; i < 40 && !if_valid; i++) step();
        check_eq(tag, 32'(if_valid), 32'd1);
    endtask

    initial begin
        @(negedge clk);

        // ---- reset values, zero-wait sequential fetch, wrap instance
        assert_reset();
        check_eq("rst_req", 32'(mem_req_o), 32'd0);
        check_eq("rst_addr", mem_addr_o, RST_PC);
        check_eq("rst_w_addr", w_mem_addr_o, RST_PC_W);
        check_eq("rst_if_pc", if_pc, 32'd0);
        check_eq("rst_if_inst", if_inst, 32'd0);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_fault", 32'(if_fault_o), 32'd0);
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        release_reset();
        for (int i = 0; i < 12; i++) begin
            check_eq("w_valid", 32'(w_if_valid), 32'(if_valid));
            if (if_valid) begin
                check_eq("w_pc", w_if_pc, if_pc - 32'd8);
                check_eq("w_inst", w_if_inst, if_inst);
                check_eq("w_fault", 32'(w_if_fault_o), 32'd0);
            end
            step();
        end
        check_eq("p1_ngrant", 32'(grants.size() >= 3), 32'd1);
        check_eq("p1_nxfer", 32'(xfers.size() >= 3), 32'd1);
        if (grants.size() >= 3 && xfers.size() >= 3) begin
            check_eq("p1_addr0", grants[0], 32'h0);
            check_eq("p1_addr1", grants[1], 32'h4);
            check_eq("p1_addr2", grants[2], 32'h8);
            check_eq("p1_waddr0", w_grants[0], 32'hFFFF_FFF8);
            check_eq("p1_waddr1", w_grants[1], 32'hFFFF_FFFC);
            check_eq("p1_waddr2", w_grants[2], 32'h0);
            check_eq("p1_xfer0", xfers[0], 32'h0);
            check_eq("p1_xfer1", xfers[1], 32'h4);
            check_eq("p1_xfer2", xfers[2], 32'h8);
        end
        check_eq("p1_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'd2);

        // ---- stall for 5 cycles with response for 0x4 landing in skid
        assert_reset();
        release_reset();
        run_until_valid("p2_first_valid");
        check_eq("p2_pc0", if_pc, 32'h0);
        stall_i = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("p2_noreq", 32'(mem_req_o), 32'd0);
            step();
        end
        check_eq("p2_still_pc0", if_pc, 32'h0);
        stall_i = 1'b0;
        step();
        check_eq("p2_skid_valid", 32'(if_valid), 32'd1);
        check_eq("p2_skid_pc", if_pc, 32'h4);
        check_eq("p2_skid_inst", if_inst, mem_word(32'h4));
        check_eq("p2_next_req", 32'(mem_req_o), 32'd1);
        check_eq("p2_next_addr", mem_addr_o, 32'h8);

        // ---- redirect in the cycle after the grant for 0x8
        assert_reset();
        lat_min = 2; lat_max = 2;
        release_reset();
        for (int i = 0; i < 40 && !(mem_req_o && mem_addr_o == 32'h8); i++) step();
        check_eq("p3_reach8", 32'(mem_req_o && mem_addr_o == 32'h8), 32'd1);
        step();
        do_redirect(32'h100);
        for (int i = 0; i < 20 && !mem_req_o; i++) step();
        check_eq("p3_req_after", 32'(mem_req_o), 32'd1);
        check_eq("p3_addr_after", mem_addr_o, 32'h100);
        run_until_valid("p3_valid");
        check_eq("p3_pc", if_pc, 32'h100);
        check_eq("p3_inst", if_inst, mem_word(32'h100));

        // ---- redirect while stalled with output and skid both full
        assert_reset();
        lat_min = 1; lat_max = 1;
        release_reset();
        run_until_valid("p4_first_valid");
        stall_i = 1'b1;
        step();
        step();
        check_eq("p4_hold_noreq", 32'(mem_req_o), 32'd0);
        do_redirect(32'h200);
        check_eq("p4_cleared", 32'(if_valid), 32'd0);
        check_eq("p4_req", 32'(mem_req_o), 32'd1);
        check_eq("p4_addr", mem_addr_o, 32'h200);
        stall_i = 1'b0;
        run_until_valid("p4_valid");
        check_eq("p4_pc", if_pc, 32'h200);

        // ---- reset while waiting; a late response after release is ignored
        assert_reset();
        lat_min = 3; lat_max = 3;
        release_reset();
        for (int i = 0; i < 40 && !(mem_req_o && mem_addr_o == 32'h4); i++) step();
        check_eq("p5_reach4", 32'(mem_req_o && mem_addr_o == 32'h4), 32'd1);
        step();
        check_eq("p5_in_wait", 32'(mem_req_o), 32'd0);
        assert_reset();
        lat_min = 1; lat_max = 1;
        release_reset();
        stale_cycles = 2;
        run_until_valid("p5_valid");
        check_eq("p5_pc", if_pc, RST_PC);
        check_eq("p5_inst", if_inst, mem_word(RST_PC));
        check_eq("p5_first_grant", (grants.size() > 0) ? grants[0] : 32'hFFFF_FFFF, RST_PC);

        // ---- misaligned redirect target
        assert_reset();
        release_reset();
        run_until_valid("p6_first_valid");
        for (int i = 0; i < 20 && !mem_req_o; i++) step();
        gnt_pct = 0;
        do_redirect(32'h102);
        gnt_pct = 100;
`ifdef IF_MISALIGN_CHECK_EN
        check_eq("p6_fault_valid", 32'(if_valid), 32'd1);
        check_eq("p6_fault_pc", if_pc, 32'h102);
        check_eq("p6_fault_inst", if_inst, NOP);
        check_eq("p6_fault_flag", 32'(if_fault_o), 32'd1);
        check_eq("p6_noreq", 32'(mem_req_o), 32'd0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("p6_stall_noreq", 32'(mem_req_o), 32'd0);
        end
        stall_i = 1'b0;
        step();
        check_eq("p6_dropped", 32'(if_valid), 32'd0);
        check_eq("p6_fault_clr", 32'(if_fault_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("p6_parked_noreq", 32'(mem_req_o), 32'd0);
        end
        do_redirect(32'h300);
        run_until_valid("p6_resume_valid");
        check_eq("p6_resume_pc", if_pc, 32'h300);
`else
        check_eq("p6_masked_req", 32'(mem_req_o), 32'd1);
        check_eq("p6_masked_addr", mem_addr_o, 32'h100);
        check_eq("p6_nofault", 32'(if_fault_o), 32'd0);
        run_until_valid("p6_masked_valid");
        check_eq("p6_masked_pc", if_pc, 32'h100);
        check_eq("p6_masked_fault", 32'(if_fault_o), 32'd0);
`endif

        // ---- randomized traffic against the stream model
        assert_reset();
        gnt_pct = 60; lat_min = 1; lat_max = 3;
        release_reset();
        for (int i = 0; i < 3000; i++) begin
            stall_i = ($urandom_range(99) < 30);
            if ($urandom_range(99) < 4) begin
                logic [31:0] t;
                if ($urandom_range(3) == 0)
                    t = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
                else
                    t = 32'($urandom_range(255)) * 32'd4;
`ifndef IF_MISALIGN_CHECK_EN
                t = t | 32'($urandom_range(3));
`endif
                do_redirect(t);
            end else begin
                step();
            end
        end
        stall_i = 1'b0;
        check_eq("p7_progress", 32'(xfers.size() > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
